// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter in front of a single-port synchronous RAM
// Define RAM_ARB_FIXED_PRI_EN to make port A win every tie instead of round-robin.
module ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              FAB_RESET_N,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              any_req;
    logic              pick_b;
    logic              grant_b;
    logic              grant_we;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    assign any_req = a_req | b_req;

`ifndef RAM_ARB_FIXED_PRI_EN
    logic last_b;

    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            last_b <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_b <= pick_b;
        end
    end
`endif

    // A lone requester always wins; only a tie consults the priority rule.
    always_comb begin
        pick_b = b_req & ~a_req;
        if (a_req && b_req) begin
`ifdef RAM_ARB_FIXED_PRI_EN
            pick_b = 1'b0;
`else
            pick_b = ~last_b;
`endif
        end
    end

    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ACC;
            ACC:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes are launched on entry to ACC; ram_we is withdrawn on leaving it.
    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            grant_b  <= 1'b0;
            grant_we <= 1'b0;
        end else if (state == IDLE && any_req) begin
            grant_b  <= pick_b;
            grant_we <= pick_b ? b_we : a_we;
            ram_we   <= pick_b ? b_we : a_we;
            ram_addr <= pick_b ? b_addr : a_addr;
            ram_din  <= pick_b ? b_wdata : a_wdata;
        end else if (state == ACC) begin
            ram_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (state == DONE && !grant_we) begin
            if (grant_b) begin
                b_rdata_q <= ram_dout;
            end else begin
                a_rdata_q <= ram_dout;
            end
        end
    end

    // RAM data only arrives in DONE, so the ack cycle forwards it and later cycles hold the copy.
    assign a_ack   = (state == DONE) && !grant_b;
    assign b_ack   = (state == DONE) && grant_b;
    assign a_rdata = (a_ack && !grant_we) ? ram_dout : a_rdata_q;
    assign b_rdata = (b_ack && !grant_we) ? ram_dout : b_rdata_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM/arbitration model
module tb_ram_arbiter;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [14:0] addr_v  [2];
    logic [7:0]  wdata_v [2];
    logic        ack_v   [2];
    logic [7:0]  rdata_v [2];
    logic        a_ack, b_ack, ram_we, busy;
    logic [7:0]  a_rdata, b_rdata, ram_din, ram_dout;
    logic [14:0] ram_addr;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    txn_t q0[$];
    txn_t q1[$];
    int   ack_log[$];
    logic [7:0] ram       [0:32767];
    logic [7:0] model_mem [0:32767];

    ram_arbiter dut (
        .clk(clk), .FAB_RESET_N(rst_n),
        .a_req(req_v[0]), .a_we(we_v[0]), .a_addr(addr_v[0]), .a_wdata(wdata_v[0]),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(req_v[1]), .b_we(we_v[1]), .b_addr(addr_v[1]), .b_wdata(wdata_v[1]),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .busy(busy)
    );

    assign ack_v[0]   = a_ack;
    assign ack_v[1]   = b_ack;
    assign rdata_v[0] = a_rdata;
    assign rdata_v[1] = b_rdata;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        ram[15'h1234] = 8'h5A;
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_addr] <= ram_din;
            ram_dout <= ram[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [14:0] ad, input logic [7:0] d);
        txn_t tr;
        tr.we = w; tr.addr = ad; tr.data = d;
        we_v[p] = w; addr_v[p] = ad; wdata_v[p] = d; req_v[p] = 1'b1;
        if (p == 0) q0.push_back(tr); else q1.push_back(tr);
    endtask

    task automatic wait_ack(input int p, output int t);
        int n;
        n = 0;
        t = -1;
        while (n < 200) begin
            @(negedge clk);
            if (ack_v[p]) begin t = cyc; break; end
            n++;
        end
        if (t < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout: port %0d got no ack within 200 cycles, required ack", p);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_seq(input int p, input int n, input logic [14:0] base);
        int t;
        for (int k = 0; k < n; k++) begin
            issue(p, 1'(k % 2 == 0), base + 15'(k / 2), 8'(8'h40 + k + p * 16));
            wait_ack(p, t);
        end
        req_v[p] = 1'b0;
    endtask

    task automatic run_port(input int p, input int n);
        int t;
        logic [14:0] ad;
        for (int k = 0; k < n; k++) begin
            if (k == 0 || $urandom_range(0, 2) == 0) begin
                req_v[p] = 1'b0;
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 3))
                0:       ad = 15'h0000;
                1:       ad = 15'h7FFF;
                default: ad = 15'($urandom_range(0, 31));
            endcase
            issue(p, 1'($urandom_range(0, 1)), ad, 8'($urandom));
            wait_ack(p, t);
        end
        req_v[p] = 1'b0;
    endtask

    // Monitor: model memory updated in ack order, arbitration and latency judged from request history.
    initial begin
        int   start [2];
        bit   pend  [2];
        logic [7:0] hold_exp [2];
        int   last_port, wecnt, lat, exp_w;
        bit   other, empty;
        txn_t tr;
        last_port = 1; wecnt = 0;
        pend[0] = 0; pend[1] = 0; start[0] = 0; start[1] = 0;
        hold_exp[0] = 8'h00; hold_exp[1] = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_port = 1; wecnt = 0;
                pend[0] = 0; pend[1] = 0;
                hold_exp[0] = 8'h00; hold_exp[1] = 8'h00;
                q0.delete(); q1.delete();
            end else begin
                for (int p = 0; p < 2; p++)
                    if (req_v[p] && !pend[p]) begin pend[p] = 1; start[p] = cyc; end
                chk("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
                if (ram_we) wecnt++;
                for (int p = 0; p < 2; p++) begin
                    if (!ack_v[p]) begin
                        chk(p == 0 ? "a_rdata_hold" : "b_rdata_hold", 32'(rdata_v[p]), 32'(hold_exp[p]));
                    end else begin
                        empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
                        chk("ack_has_request", 32'(empty), 32'd0);
                        if (!empty) begin
                            tr = (p == 0) ? q0.pop_front() : q1.pop_front();
                            chk("ram_addr", 32'(ram_addr), 32'(tr.addr));
                            chk("we_pulse_cycles", 32'(wecnt), tr.we ? 32'd1 : 32'd0);
                            if (tr.we) begin
                                chk("ram_din", 32'(ram_din), 32'(tr.data));
                                chk("rdata_on_write", 32'(rdata_v[p]), 32'(hold_exp[p]));
                                model_mem[tr.addr] = tr.data;
                            end else begin
                                chk(p == 0 ? "a_rdata" : "b_rdata", 32'(rdata_v[p]), 32'(model_mem[tr.addr]));
                                hold_exp[p] = model_mem[tr.addr];
                            end
                        end
                        chk("busy_in_done", 32'(busy), 32'd1);
                        lat = cyc - start[p];
                        chk("latency_min", 32'(lat >= 2), 32'd1);
`ifdef RAM_ARB_FIXED_PRI_EN
                        if (p == 0) chk("latency_max", 32'(lat <= 5), 32'd1);
`else
                        chk("latency_max", 32'(lat <= 5), 32'd1);
`endif
                        other = pend[1-p] && (start[1-p] <= cyc - 2);
                        if (other) begin
`ifdef RAM_ARB_FIXED_PRI_EN
                            exp_w = 0;
`else
                            exp_w = 1 - last_port;
`endif
                            chk("tie_winner", 32'(p), 32'(exp_w));
                        end
                        last_port = p;
                        pend[p] = 0;
                        wecnt = 0;
                        ack_log.push_back(p);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        int exp_order[$];
        for (int i = 0; i < 32768; i++) model_mem[i] = 8'h00;
        model_mem[15'h1234] = 8'h5A;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
        end
        #2;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_acks", 32'({a_ack, b_ack}), 32'd0);
        chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 1'b0, 15'h1234, 8'h00);
        t0 = cyc;
        wait_ack(0, t1);
        req_v[0] = 1'b0;
        chk("single_read_latency", 32'(t1 - t0), 32'd2);

        issue(1, 1'b1, 15'h7FFF, 8'hC3);
        wait_ack(1, t1);
        issue(1, 1'b0, 15'h7FFF, 8'h00);
        wait_ack(1, t2);
        req_v[1] = 1'b0;
        chk("b_readback_7fff", 32'(b_rdata), 32'hC3);

        issue(0, 1'b0, 15'h0010, 8'h00);
        t0 = cyc;
        wait_ack(0, t1);
        issue(0, 1'b0, 15'h0011, 8'h00);
        wait_ack(0, t2);
        req_v[0] = 1'b0;
        chk("b2b_first_ack", 32'(t1 - t0), 32'd2);
        chk("b2b_second_ack", 32'(t2 - t0), 32'd5);

        issue(1, 1'b1, 15'h0042, 8'h99);
        @(posedge clk); #3;
        chk("acc_ram_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        req_v[1] = 1'b0;
        #1;
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_acks", 32'({a_ack, b_ack}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 1'b1, 15'h0042, 8'h77);
        wait_ack(1, t1);
        issue(1, 1'b0, 15'h0042, 8'h00);
        wait_ack(1, t1);
        req_v[1] = 1'b0;
        chk("post_reset_read", 32'(b_rdata), 32'h77);

        ack_log.delete();
        fork
            run_seq(0, 3, 15'h0100);
            run_seq(1, 3, 15'h0200);
        join
`ifdef RAM_ARB_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        chk("tie_ack_count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            chk("tie_ack_order", 32'(ack_log[i]), 32'(exp_order[i]));

        fork
            run_port(0, 60);
            run_port(1, 60);
        join
        repeat (4) @(posedge clk);
        chk("queue_a_drained", 32'(q0.size()), 32'd0);
        chk("queue_b_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
